// File: rtl/alu_pkg.sv
// Shared types for ALU initiators: opcodes, one-hot control codes, issuer FSM states.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  localparam logic [3:0] CTRL_ADD = 4'b0001;
  localparam logic [3:0] CTRL_SUB = 4'b0010;
  localparam logic [3:0] CTRL_AND = 4'b0100;
  localparam logic [3:0] CTRL_OR  = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_RESP  = 2'b10
  } state_e;

endpackage

// File: rtl/alu_op_encoder.sv
// Combinational 2-bit opcode to 4-bit one-hot ALU control.
module alu_op_encoder
  import alu_pkg::*;
(
  input  logic [1:0] op,
  output logic [3:0] ctrl
);

  always_comb begin
    ctrl = 4'b0000;
    case (alu_op_e'(op))
      OP_ADD:  ctrl = CTRL_ADD;
      OP_SUB:  ctrl = CTRL_SUB;
      OP_AND:  ctrl = CTRL_AND;
      OP_OR:   ctrl = CTRL_OR;
      default: ctrl = 4'b0000;
    endcase
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Initiator for one combinational ALU: accept command, drive ALU, settle, return response.
// Optional accumulator feedback into operand A is enabled with `define ALU_ACC_EN.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
`ifdef ALU_ACC_EN
  input  logic              cmd_acc,
`endif
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic              busy
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e            state;
  alu_op_e           op_q;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        ctrl_nxt;
  logic [DATA_W-1:0] a_sel;
  logic              capture;

  alu_op_encoder u_enc (
    .op   (cmd_op),
    .ctrl (ctrl_nxt)
  );

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign capture   = (state == ST_DRIVE) && (cnt == '0);

`ifdef ALU_ACC_EN
  logic [DATA_W-1:0] acc;

  assign a_sel = cmd_acc ? acc : cmd_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       acc <= '0;
    else if (capture) acc <= alu_result;
  end
`else
  assign a_sel = cmd_a;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_q       <= OP_ADD;
      cnt        <= '0;
      alu_ctrl   <= 4'b0000;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            alu_ctrl <= ctrl_nxt;
            alu_a    <= a_sel;
            alu_b    <= cmd_b;
            op_q     <= alu_op_e'(cmd_op);
            cnt      <= CNT_LOAD;
            state    <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (cnt == '0) begin
            // ALU carry is only the A+B carry, so it is meaningful for ADD alone
            rsp_result <= alu_result;
            rsp_carry  <= (op_q == OP_ADD) && alu_carry;
            rsp_zero   <= (alu_result == '0);
            rsp_valid  <= 1'b1;
            alu_ctrl   <= 4'b0000;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Two issuers (SETTLE_CYCLES 1 and 3) each driving a behavioural ALU, checked against a reference model.
module tb_alu_cmd_issuer;

  localparam int N = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic [7:0]        cmd_a, cmd_b;
  logic              cmd_acc;
  logic              rsp_ready;

  logic [N-1:0]      cmd_ready, rsp_valid, rsp_carry, rsp_zero, busy, alu_carry;
  logic [N-1:0][3:0] alu_ctrl;
  logic [N-1:0][7:0] alu_a, alu_b, alu_result, rsp_result;

  int total = 0;
  int bad   = 0;
  logic [7:0] acc_m = 8'h00;

  always #5 clk = ~clk;

  function automatic int sc(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [8:0] sum;
    assign sum          = {1'b0, alu_a[g]} + {1'b0, alu_b[g]};
    assign alu_carry[g] = sum[8];
    assign alu_result[g] =
      (alu_ctrl[g] == 4'b0001) ? sum[7:0] :
      (alu_ctrl[g] == 4'b0010) ? alu_a[g] - alu_b[g] :
      (alu_ctrl[g] == 4'b0100) ? alu_a[g] & alu_b[g] :
      (alu_ctrl[g] == 4'b1000) ? alu_a[g] | alu_b[g] : 8'h00;

    alu_cmd_issuer #(.DATA_W(8), .SETTLE_CYCLES((g == 0) ? 1 : 3)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready[g]),
      .cmd_op     (cmd_op),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
`ifdef ALU_ACC_EN
      .cmd_acc    (cmd_acc),
`endif
      .alu_ctrl   (alu_ctrl[g]),
      .alu_a      (alu_a[g]),
      .alu_b      (alu_b[g]),
      .alu_result (alu_result[g]),
      .alu_carry  (alu_carry[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result[g]),
      .rsp_carry  (rsp_carry[g]),
      .rsp_zero   (rsp_zero[g]),
      .busy       (busy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {carry, result} as the issuer should report it
  function automatic logic [8:0] ref_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {1'b0, 8'(a - b)};
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  task automatic check_idle_reset(input string tag);
    for (int g = 0; g < N; g++) begin
      chk({tag, "_ctrl"}, alu_ctrl[g], 4'h0);
      chk({tag, "_a"}, alu_a[g], 8'h00);
      chk({tag, "_b"}, alu_b[g], 8'h00);
      chk({tag, "_rvalid"}, rsp_valid[g], 1'b0);
      chk({tag, "_rres"}, rsp_result[g], 8'h00);
      chk({tag, "_rcarry"}, rsp_carry[g], 1'b0);
      chk({tag, "_rzero"}, rsp_zero[g], 1'b0);
      chk({tag, "_busy"}, busy[g], 1'b0);
      chk({tag, "_cready"}, cmd_ready[g], 1'b1);
    end
  endtask

  // One command through both issuers; hold = extra cycles of response backpressure
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic use_acc, input int hold);
    logic [7:0] a_eff;
    logic [8:0] exp;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = use_acc; rsp_ready = 1'b0;
    a_eff = a;
`ifdef ALU_ACC_EN
    if (use_acc) a_eff = acc_m;
`endif
    exp = ref_alu(op, a_eff, b);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int g = 0; g < N; g++) begin
      chk({tag, "_busy"}, busy[g], 1'b1);
      chk({tag, "_cready0"}, cmd_ready[g], 1'b0);
      chk({tag, "_ctrl"}, alu_ctrl[g], 4'b0001 << op);
      chk({tag, "_alua"}, alu_a[g], a_eff);
      chk({tag, "_alub"}, alu_b[g], b);
    end
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      for (int g = 0; g < N; g++) begin
        if (k == sc(g)) begin
          chk({tag, "_rvalid"}, rsp_valid[g], 1'b1);
          chk({tag, "_rres"}, rsp_result[g], exp[7:0]);
          chk({tag, "_rcarry"}, rsp_carry[g], exp[8]);
          chk({tag, "_rzero"}, rsp_zero[g], exp[7:0] == 8'h00);
          chk({tag, "_ctrl_off"}, alu_ctrl[g], 4'h0);
        end else if (k < sc(g)) begin
          chk({tag, "_early"}, rsp_valid[g], 1'b0);
          chk({tag, "_ctrl_hold"}, alu_ctrl[g], 4'b0001 << op);
        end
      end
    end
    acc_m = exp[7:0];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_a = ~a; cmd_b = ~b;
      @(posedge clk); #1;
      for (int g = 0; g < N; g++) begin
        chk({tag, "_bp_valid"}, rsp_valid[g], 1'b1);
        chk({tag, "_bp_res"}, rsp_result[g], exp[7:0]);
        chk({tag, "_bp_carry"}, rsp_carry[g], exp[8]);
        chk({tag, "_bp_cready"}, cmd_ready[g], 1'b0);
        chk({tag, "_bp_alua"}, alu_a[g], a_eff);
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    for (int g = 0; g < N; g++) begin
      chk({tag, "_done_valid"}, rsp_valid[g], 1'b0);
      chk({tag, "_done_cready"}, cmd_ready[g], 1'b1);
      chk({tag, "_done_alub"}, alu_b[g], b);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_a = 8'h00; cmd_b = 8'h00;
    cmd_acc = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_idle_reset("rst");
    @(negedge clk) rst_n = 1'b1;

    // T1: reset while the slow issuer is still in DRIVE
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_a = 8'hF0; cmd_b = 8'h20;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("t1_pre_busy", busy[1], 1'b1);
    rst_n = 1'b0;
    #1 check_idle_reset("t1");
    acc_m = 8'h00;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t1_cready", cmd_ready, 2'b11);
    chk("t1_rvalid", rsp_valid, 2'b00);

    run_cmd("t2_add", 2'd0, 8'hF0, 8'h20, 1'b0, 0);
    run_cmd("t3_sub0", 2'd1, 8'h05, 8'h05, 1'b0, 0);
    run_cmd("t3_subneg", 2'd1, 8'h03, 8'h04, 1'b0, 0);
    run_cmd("t3_subcy", 2'd1, 8'hF0, 8'h20, 1'b0, 0);
    run_cmd("t4_and", 2'd2, 8'hC3, 8'h5A, 1'b0, 0);
    run_cmd("t4_or", 2'd3, 8'hC3, 8'h5A, 1'b0, 0);
    run_cmd("t5_bp", 2'd0, 8'h7F, 8'h01, 1'b0, 5);

`ifdef ALU_ACC_EN
    run_cmd("t6_add", 2'd0, 8'h10, 8'h01, 1'b0, 0);
    run_cmd("t6_acc", 2'd0, 8'hAA, 8'h02, 1'b1, 0);
    @(negedge clk) rst_n = 1'b0;
    acc_m = 8'h00;
    @(negedge clk) rst_n = 1'b1;
    run_cmd("t6_accrst", 2'd0, 8'h55, 8'h05, 1'b1, 0);
`endif

    for (int i = 0; i < 24; i++) begin
      run_cmd("rnd", 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
